axis_stream_proc: RTL and testbench

AXIS_STREAM_PROC -- requirements
Module: axis_stream_proc

---
 rtl/axis_proc_pkg.sv | 24 ++
 rtl/axis_sync_fifo.sv | 61 ++++++
 rtl/axis_stream_proc.sv | 95 +++++++++
 tb/tb_axis_stream_proc.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_proc_pkg.sv
// Shared mode encodings and the per-byte data transform used by the stream processor.
package axis_proc_pkg;

  typedef enum logic [1:0] {
    MODE_PASS  = 2'b00,
    MODE_INV   = 2'b01,
    MODE_BCAST = 2'b10,
    MODE_ZERO  = 2'b11
  } mode_e;

  // One output lane; lane0 is byte 0 of the beat, needed for broadcast.
  function automatic logic [7:0] xform_byte(input mode_e m, input logic [7:0] lane,
                                            input logic [7:0] lane0);
    logic [7:0] r;
    case (m)
      MODE_PASS:  r = lane;
      MODE_INV:   r = ~lane;
      MODE_BCAST: r = lane0;
      default:    r = 8'h00;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/axis_sync_fifo.sv
// Synchronous FIFO with registered write-ready and first-word-fall-through read port.
module axis_sync_fifo #(
  parameter int W     = 37,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wr_en,
  input  logic [W-1:0]               wr_data,
  output logic                       wr_ready,
  input  logic                       rd_en,
  output logic [W-1:0]               rd_data,
  output logic                       rd_valid,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [LW-1:0] level_next;
  logic          push;
  logic          pop;

  assign push     = wr_en && wr_ready;
  assign rd_valid = (level != '0);
  assign pop      = rd_en && rd_valid;
  // Empty FIFO presents zeros so the output bus is clean after reset.
  assign rd_data  = rd_valid ? mem[rd_ptr] : '0;

  always_comb begin
    level_next = level;
    case ({push, pop})
      2'b10:   level_next = level + LW'(1);
      2'b01:   level_next = level - LW'(1);
      default: level_next = level;
    endcase
  end

  // Pointers are AW bits wide with DEPTH a power of two, so they wrap modulo DEPTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      wr_ready <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      level    <= level_next;
      wr_ready <= (level_next < LW'(DEPTH));
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/axis_stream_proc.sv
// AXI-Stream processor: per-frame data transform at FIFO write, frame/beat statistics on output.
module axis_stream_proc
  import axis_proc_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 8,
  parameter int CNT_W  = 16
) (
  input  logic                     s_axis_aclk,
  input  logic                     s_axis_aresetn,
  input  logic [DATA_W-1:0]        s_axis_tdata,
  input  logic [DATA_W/8-1:0]      s_axis_tkeep,
  input  logic                     s_axis_tlast,
  input  logic                     s_axis_tvalid,
  output logic                     s_axis_tready,
  output logic [DATA_W-1:0]        m_axis_tdata,
  output logic [DATA_W/8-1:0]      m_axis_tkeep,
  output logic                     m_axis_tlast,
  output logic                     m_axis_tvalid,
  input  logic                     m_axis_tready,
  input  logic [1:0]               mode,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic [CNT_W-1:0]         frame_cnt,
  output logic [CNT_W-1:0]         last_frame_beats,
  output logic                     keep_err
);

  localparam int KW = DATA_W / 8;
  localparam int FW = DATA_W + KW + 1;

  logic              in_xfer;
  logic              out_xfer;
  logic              sof;
  mode_e             held_mode;
  mode_e             eff_mode;
  logic [DATA_W-1:0] xdata;
  logic [FW-1:0]     rd_data;
  logic [CNT_W-1:0]  beat_cnt;

  assign in_xfer  = s_axis_tvalid && s_axis_tready;
  assign out_xfer = m_axis_tvalid && m_axis_tready;
  // The first beat of a frame uses the live mode; the rest reuse the value captured then.
  assign eff_mode = sof ? mode_e'(mode) : held_mode;

  always_comb begin
    xdata = '0;
    for (int i = 0; i < KW; i++) begin
      xdata[i*8 +: 8] = xform_byte(eff_mode, s_axis_tdata[i*8 +: 8], s_axis_tdata[7:0]);
    end
  end

  axis_sync_fifo #(.W(FW), .DEPTH(DEPTH)) u_fifo (
    .clk      (s_axis_aclk),
    .rst_n    (s_axis_aresetn),
    .wr_en    (s_axis_tvalid),
    .wr_data  ({xdata, s_axis_tkeep, s_axis_tlast}),
    .wr_ready (s_axis_tready),
    .rd_en    (m_axis_tready),
    .rd_data  (rd_data),
    .rd_valid (m_axis_tvalid),
    .level    (fifo_level)
  );

  assign {m_axis_tdata, m_axis_tkeep, m_axis_tlast} = rd_data;

  always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
    if (!s_axis_aresetn) begin
      sof       <= 1'b1;
      held_mode <= MODE_PASS;
      keep_err  <= 1'b0;
    end else if (in_xfer) begin
      if (sof) held_mode <= mode_e'(mode);
      sof <= s_axis_tlast;
      if (s_axis_tkeep != '1) keep_err <= 1'b1;
    end
  end

  // Counters wrap naturally on overflow.
  always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
    if (!s_axis_aresetn) begin
      beat_cnt         <= '0;
      frame_cnt        <= '0;
      last_frame_beats <= '0;
    end else if (out_xfer) begin
      if (m_axis_tlast) begin
        last_frame_beats <= beat_cnt + CNT_W'(1);
        beat_cnt         <= '0;
        frame_cnt        <= frame_cnt + CNT_W'(1);
      end else begin
        beat_cnt <= beat_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_axis_stream_proc.sv
// Directed and randomized bench for axis_stream_proc with a queue-based scoreboard.
module tb_axis_stream_proc;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 8;
  localparam int CNT_W  = 16;
  localparam int KW     = DATA_W / 8;
  localparam int LW     = $clog2(DEPTH) + 1;
  localparam int BW     = DATA_W + KW + 1;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [DATA_W-1:0] s_axis_tdata = '0;
  logic [KW-1:0]     s_axis_tkeep = '0;
  logic              s_axis_tlast = 1'b0;
  logic              s_axis_tvalid = 1'b0;
  logic              s_axis_tready;
  logic [DATA_W-1:0] m_axis_tdata;
  logic [KW-1:0]     m_axis_tkeep;
  logic              m_axis_tlast;
  logic              m_axis_tvalid;
  logic              m_axis_tready = 1'b0;
  logic [1:0]        mode = 2'b00;
  logic [LW-1:0]     fifo_level;
  logic [CNT_W-1:0]  frame_cnt;
  logic [CNT_W-1:0]  last_frame_beats;
  logic              keep_err;

  axis_stream_proc #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .s_axis_aclk      (clk),
    .s_axis_aresetn   (rst_n),
    .s_axis_tdata     (s_axis_tdata),
    .s_axis_tkeep     (s_axis_tkeep),
    .s_axis_tlast     (s_axis_tlast),
    .s_axis_tvalid    (s_axis_tvalid),
    .s_axis_tready    (s_axis_tready),
    .m_axis_tdata     (m_axis_tdata),
    .m_axis_tkeep     (m_axis_tkeep),
    .m_axis_tlast     (m_axis_tlast),
    .m_axis_tvalid    (m_axis_tvalid),
    .m_axis_tready    (m_axis_tready),
    .mode             (mode),
    .fifo_level       (fifo_level),
    .frame_cnt        (frame_cnt),
    .last_frame_beats (last_frame_beats),
    .keep_err         (keep_err)
  );

  // Clock; inputs change 1 time unit after posedge, outputs are sampled on negedge.
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] model_xf(input logic [1:0] m, input logic [DATA_W-1:0] d);
    logic [DATA_W-1:0] r;
    case (m)
      2'b00:   r = d;
      2'b01:   r = ~d;
      2'b10:   r = {KW{d[7:0]}};
      default: r = '0;
    endcase
    return r;
  endfunction

  // Scoreboard and reference model, updated from the transfers seen on each negedge.
  logic [BW-1:0]    exp_q[$];
  int               mdl_level = 0;
  logic [CNT_W-1:0] mdl_frames = '0;
  logic [CNT_W-1:0] mdl_last = '0;
  logic [CNT_W-1:0] mdl_beats = '0;
  logic             mdl_kerr = 1'b0;
  logic             mdl_sof = 1'b1;
  logic [1:0]       mdl_mode = 2'b00;
  logic             hold_prev = 1'b0;
  logic [BW-1:0]    prev_out = '0;

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      mdl_level  = 0;
      mdl_frames = '0;
      mdl_last   = '0;
      mdl_beats  = '0;
      mdl_kerr   = 1'b0;
      mdl_sof    = 1'b1;
      mdl_mode   = 2'b00;
      hold_prev  = 1'b0;
    end else begin
      check("fifo_level", 64'(fifo_level), 64'(mdl_level));
      check("level_bound", 64'(fifo_level <= LW'(DEPTH)), 64'd1);
      check("m_tvalid", 64'(m_axis_tvalid), 64'(mdl_level != 0));
      check("frame_cnt", 64'(frame_cnt), 64'(mdl_frames));
      check("last_frame_beats", 64'(last_frame_beats), 64'(mdl_last));
      check("keep_err", 64'(keep_err), 64'(mdl_kerr));
      if (hold_prev) check("out_stable", 64'({m_axis_tdata, m_axis_tkeep, m_axis_tlast}), 64'(prev_out));
      hold_prev = m_axis_tvalid && !m_axis_tready;
      prev_out  = {m_axis_tdata, m_axis_tkeep, m_axis_tlast};
      if (m_axis_tvalid && m_axis_tready) begin
        check("q_nonempty", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) begin
          check("out_beat", 64'({m_axis_tdata, m_axis_tkeep, m_axis_tlast}), 64'(exp_q.pop_front()));
        end
        if (m_axis_tlast) begin
          mdl_last   = mdl_beats + CNT_W'(1);
          mdl_beats  = '0;
          mdl_frames = mdl_frames + CNT_W'(1);
        end else begin
          mdl_beats = mdl_beats + CNT_W'(1);
        end
        mdl_level--;
      end
      if (s_axis_tvalid && s_axis_tready) begin
        if (mdl_sof) mdl_mode = mode;
        exp_q.push_back({model_xf(mdl_mode, s_axis_tdata), s_axis_tkeep, s_axis_tlast});
        mdl_sof = s_axis_tlast;
        if (s_axis_tkeep != '1) mdl_kerr = 1'b1;
        mdl_level++;
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Present one beat and hold it until accepted; returns 1 unit after the accepting edge.
  task automatic send_beat(input logic [DATA_W-1:0] d, input logic [KW-1:0] k, input logic l);
    bit acc = 1'b0;
    int budget = 0;
    s_axis_tdata  = d;
    s_axis_tkeep  = k;
    s_axis_tlast  = l;
    s_axis_tvalid = 1'b1;
    while (!acc) begin
      @(negedge clk);
      acc = s_axis_tready;
      @(posedge clk);
      #1;
      budget++;
      if (!acc && budget > 200) begin
        check("send_timeout", 64'(s_axis_tready), 64'd1);
        break;
      end
    end
    s_axis_tvalid = 1'b0;
  endtask

  task automatic drain();
    int b = 0;
    m_axis_tready = 1'b1;
    while ((exp_q.size() != 0 || m_axis_tvalid) && b < 500) begin
      cycles(1);
      b++;
    end
    check("drain_empty", 64'(exp_q.size()), 64'd0);
  endtask

  bit rand_done;

  initial begin
    repeat (3) @(posedge clk);
    #1;
    // Reset state
    check("rst_s_tready", 64'(s_axis_tready), 64'd0);
    check("rst_m_tvalid", 64'(m_axis_tvalid), 64'd0);
    check("rst_m_tdata", 64'(m_axis_tdata), 64'd0);
    check("rst_m_tkeep", 64'(m_axis_tkeep), 64'd0);
    check("rst_m_tlast", 64'(m_axis_tlast), 64'd0);
    check("rst_level", 64'(fifo_level), 64'd0);
    check("rst_frame_cnt", 64'(frame_cnt), 64'd0);
    check("rst_keep_err", 64'(keep_err), 64'd0);
    rst_n = 1'b1;
    cycles(1);
    check("tready_after_reset", 64'(s_axis_tready), 64'd1);

    // Single-beat frame, pass-through, one-cycle latency
    m_axis_tready = 1'b1;
    mode = 2'b00;
    send_beat(32'h1234_5678, 4'hF, 1'b1);
    check("lat_tvalid", 64'(m_axis_tvalid), 64'd1);
    check("pass_data", 64'(m_axis_tdata), 64'h1234_5678);
    check("pass_tlast", 64'(m_axis_tlast), 64'd1);
    cycles(1);
    check("frame_cnt_1", 64'(frame_cnt), 64'd1);
    check("last_beats_1", 64'(last_frame_beats), 64'd1);

    // Invert and broadcast
    mode = 2'b01;
    send_beat(32'h0000_FFFF, 4'hF, 1'b1);
    check("invert_data", 64'(m_axis_tdata), 64'hFFFF_0000);
    mode = 2'b10;
    send_beat(32'hAABB_CCDD, 4'hF, 1'b1);
    check("bcast_data", 64'(m_axis_tdata), 64'hDDDD_DDDD);
    cycles(1);
    mode = 2'b00;

    // Backpressure: fill to DEPTH, hold a ninth beat, then release
    m_axis_tready = 1'b0;
    for (int i = 0; i < 8; i++) send_beat(32'hB000_0000 + 32'(i), 4'hF, 1'b0);
    s_axis_tdata  = 32'hB000_0008;
    s_axis_tkeep  = 4'hF;
    s_axis_tlast  = 1'b0;
    s_axis_tvalid = 1'b1;
    cycles(3);
    check("full_tready", 64'(s_axis_tready), 64'd0);
    check("full_level", 64'(fifo_level), 64'(DEPTH));
    check("full_head", 64'(m_axis_tdata), 64'hB000_0000);
    m_axis_tready = 1'b1;
    send_beat(32'hB000_0008, 4'hF, 1'b0);
    send_beat(32'hB000_0009, 4'hF, 1'b1);
    drain();
    check("bp_last_beats", 64'(last_frame_beats), 64'd10);

    // Mode change mid-frame must not affect the current frame
    mode = 2'b00;
    send_beat(32'hC000_0000, 4'hF, 1'b0);
    send_beat(32'hC000_0001, 4'hF, 1'b0);
    mode = 2'b11;
    send_beat(32'hC000_0002, 4'hF, 1'b0);
    check("midframe_hold", 64'(m_axis_tdata), 64'hC000_0002);
    send_beat(32'hC000_0003, 4'hF, 1'b1);
    send_beat(32'hD000_0000, 4'hF, 1'b0);
    check("next_frame_zero", 64'(m_axis_tdata), 64'd0);
    send_beat(32'hD000_0001, 4'hF, 1'b1);
    mode = 2'b00;
    drain();

    // Random traffic on both sides
    rand_done = 1'b0;
    fork
      begin
        for (int n = 0; n < 1000; n++) begin
          cycles($urandom_range(0, 2));
          mode = 2'($urandom_range(0, 3));
          send_beat($urandom, ($urandom_range(0, 15) == 0) ? 4'($urandom_range(0, 15)) : 4'hF,
                    ($urandom_range(0, 3) == 0));
        end
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          m_axis_tready = ($urandom_range(0, 2) != 0);
          cycles(1);
        end
      end
    join
    drain();

    // Reset with beats buffered, then a partial-keep beat
    m_axis_tready = 1'b0;
    mode = 2'b00;
    for (int i = 0; i < 5; i++) send_beat(32'hE000_0000 + 32'(i), 4'hF, 1'b0);
    check("pre_rst_level", 64'(fifo_level), 64'd5);
    rst_n = 1'b0;
    #1;
    check("arst_m_tvalid", 64'(m_axis_tvalid), 64'd0);
    check("arst_level", 64'(fifo_level), 64'd0);
    check("arst_frame_cnt", 64'(frame_cnt), 64'd0);
    check("arst_last_beats", 64'(last_frame_beats), 64'd0);
    check("arst_m_tdata", 64'(m_axis_tdata), 64'd0);
    check("arst_s_tready", 64'(s_axis_tready), 64'd0);
    cycles(2);
    rst_n = 1'b1;
    cycles(1);
    check("post_rst_keep_err", 64'(keep_err), 64'd0);
    m_axis_tready = 1'b1;
    send_beat(32'h0102_0304, 4'h7, 1'b1);
    cycles(1);
    check("keep_err_set", 64'(keep_err), 64'd1);
    drain();
    check("keep_err_sticky", 64'(keep_err), 64'd1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
